m_seq_checker: RTL and testbench

M_SEQ_CHECKER -- requirements
Module: m_seq_checker

---
 rtl/m_seq_checker.sv | 136 +++++++++++++
 tb/tb_m_seq_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_seq_checker.sv
// PRBS checker for the x^20 + x^3 + 1 m-sequence: hunts for alignment, then
// flywheels the reference and counts bit errors with windowed loss-of-lock.
module m_seq_checker #(
    parameter int LOCK_CNT = 32,
    parameter int ERR_WIN  = 64,
    parameter int ERR_THR  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        data,
    input  logic        clear,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_cnt,
    output logic [31:0] bit_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(ERR_WIN + 1);
    localparam int EW = $clog2(ERR_THR + 1);

    typedef enum logic {
        HUNT,
        LOCK
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [19:0]   r_sr, w_sr_nxt;
    logic [4:0]    r_fill, w_fill_nxt;
    logic [MW-1:0] r_match, w_match_nxt;
    logic [WW-1:0] r_win, w_win_nxt;
    logic [EW-1:0] r_werr, w_werr_nxt;
    logic          r_err, w_err_nxt;
    logic [15:0]   r_err_cnt, w_err_cnt_nxt;
    logic [31:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic          w_p;
    logic          w_mis;

    assign w_p   = r_sr[19] ^ r_sr[2];
    assign w_mis = data ^ w_p;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= HUNT;
            r_sr      <= '0;
            r_fill    <= '0;
            r_match   <= '0;
            r_win     <= '0;
            r_werr    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_fill    <= w_fill_nxt;
            r_match   <= w_match_nxt;
            r_win     <= w_win_nxt;
            r_werr    <= w_werr_nxt;
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_fill_nxt    = r_fill;
        w_match_nxt   = r_match;
        w_win_nxt     = r_win;
        w_werr_nxt    = r_werr;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        w_bit_cnt_nxt = r_bit_cnt;

        if (en) begin
            case (r_state)
                HUNT: begin
                    w_sr_nxt = {r_sr[18:0], data};
                    if (r_fill != 5'd20) begin
                        w_fill_nxt = r_fill + 5'd1;
                    end else if (!w_mis && (r_sr != '0)) begin
                        if (r_match == MW'(LOCK_CNT - 1)) begin
                            w_state_nxt = LOCK;
                            w_match_nxt = '0;
                            w_win_nxt   = '0;
                            w_werr_nxt  = '0;
                        end else begin
                            w_match_nxt = r_match + MW'(1);
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                LOCK: begin
                    // Flywheel: the reference follows its own prediction, not the line.
                    w_sr_nxt  = {r_sr[18:0], w_p};
                    w_err_nxt = w_mis;
                    if (r_bit_cnt != '1) begin
                        w_bit_cnt_nxt = r_bit_cnt + 32'd1;
                    end
                    if (w_mis && (r_err_cnt != '1)) begin
                        w_err_cnt_nxt = r_err_cnt + 16'd1;
                    end
                    if (w_mis && (r_werr == EW'(ERR_THR - 1))) begin
                        w_state_nxt = HUNT;
                        w_fill_nxt  = '0;
                        w_match_nxt = '0;
                        w_win_nxt   = '0;
                        w_werr_nxt  = '0;
                    end else if (r_win == WW'(ERR_WIN - 1)) begin
                        w_win_nxt  = '0;
                        w_werr_nxt = '0;
                    end else begin
                        w_win_nxt  = r_win + WW'(1);
                        w_werr_nxt = r_werr + EW'(w_mis);
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end

        if (clear) begin
            w_err_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
        end
    end

    assign locked  = (r_state == LOCK);
    assign err     = r_err;
    assign err_cnt = r_err_cnt;
    assign bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_m_seq_checker.sv
// Directed bench for m_seq_checker: queue-based reference model checked every
// cycle, plus literal expectations for lock timing, error pulses and reset.
module tb_m_seq_checker;

    localparam int LOCK_CNT = 32;
    localparam int ERR_WIN  = 64;
    localparam int ERR_THR  = 8;
    localparam longint EMAX = 64'd65535;
    localparam longint BMAX = 64'd4294967295;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        en    = 1'b0;
    logic        data  = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;

    int n_cmp  = 0;
    int n_bad  = 0;
    int err_hi = 0;

    m_seq_checker #(
        .LOCK_CNT(LOCK_CNT),
        .ERR_WIN (ERR_WIN),
        .ERR_THR (ERR_THR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .data   (data),
        .clear  (clear),
        .locked (locked),
        .err    (err),
        .err_cnt(err_cnt),
        .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_q holds the last 20 reference bits, oldest first,
    // so the prediction is b[n-20] ^ b[n-3] = m_q[0] ^ m_q[17].
    bit     m_hunt  = 1'b1;
    bit     m_q[$];
    int     m_match = 0;
    int     m_win   = 0;
    int     m_werr  = 0;
    bit     m_err   = 1'b0;
    longint m_errc  = 0;
    longint m_bitc  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hunt  = 1'b1;
            m_q.delete();
            m_match = 0;
            m_win   = 0;
            m_werr  = 0;
            m_err   = 1'b0;
            m_errc  = 0;
            m_bitc  = 0;
        end else begin
            bit p;
            bit mis;
            bit any1;
            m_err = 1'b0;
            if (en) begin
                p   = (m_q.size() == 20) ? (m_q[0] ^ m_q[17]) : 1'b0;
                mis = (data != p);
                if (m_hunt) begin
                    if (m_q.size() == 20) begin
                        any1 = 1'b0;
                        foreach (m_q[i]) any1 |= m_q[i];
                        if (!mis && any1) begin
                            m_match++;
                            if (m_match == LOCK_CNT) begin
                                m_hunt  = 1'b0;
                                m_match = 0;
                                m_win   = 0;
                                m_werr  = 0;
                            end
                        end else begin
                            m_match = 0;
                        end
                    end
                    m_q.push_back(data);
                    if (m_q.size() > 20) void'(m_q.pop_front());
                end else begin
                    m_q.push_back(p);
                    void'(m_q.pop_front());
                    if (m_bitc < BMAX) m_bitc++;
                    if (mis) begin
                        m_err = 1'b1;
                        if (m_errc < EMAX) m_errc++;
                        m_werr++;
                    end
                    m_win++;
                    if (m_werr == ERR_THR) begin
                        m_hunt  = 1'b1;
                        m_q.delete();
                        m_match = 0;
                        m_win   = 0;
                        m_werr  = 0;
                    end else if (m_win == ERR_WIN) begin
                        m_win  = 0;
                        m_werr = 0;
                    end
                end
            end
            if (clear) begin
                m_errc = 0;
                m_bitc = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("locked", locked, longint'(!m_hunt));
        chk("err", err, longint'(m_err));
        chk("err_cnt", err_cnt, m_errc);
        chk("bit_cnt", bit_cnt, m_bitc);
        if (err) err_hi++;
    end

    // Stimulus generator, seeded 1, same recurrence as the checker.
    logic [19:0] g = 20'd1;

    task automatic gen_bit(output bit b);
        b = g[19] ^ g[2];
        g = {g[18:0], b};
    endtask

    task automatic send(input bit e, input bit d, input bit c);
        en    = e;
        data  = d;
        clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic clean(input int n);
        bit b;
        repeat (n) begin
            gen_bit(b);
            send(1'b1, b, 1'b0);
        end
    endtask

    task automatic do_reset();
        en    = 1'b0;
        clear = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        g   = 20'd1;
    endtask

    initial begin
        bit b;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        rst = 1'b1;

        // Clean acquisition: lock on valid bit 52.
        clean(51);
        chk("lock_bit51", locked, 0);
        clean(1);
        chk("lock_bit52", locked, 1);
        chk("lock_bit_cnt0", bit_cnt, 0);
        clean(10);
        chk("bit_cnt_10", bit_cnt, 10);
        chk("err_cnt_clean", err_cnt, 0);

        // Single inverted bit while locked.
        gen_bit(b);
        send(1'b1, ~b, 1'b0);
        chk("single_err_pulse", err, 1);
        chk("single_err_cnt", err_cnt, 1);
        chk("single_locked", locked, 1);
        clean(1);
        chk("single_err_gone", err, 0);
        clean(4);

        // Finish the 64-bit window, clearing stats on its last bit.
        clean(47);
        gen_bit(b);
        send(1'b1, b, 1'b1);
        chk("clear_err_cnt", err_cnt, 0);
        chk("clear_bit_cnt", bit_cnt, 0);
        chk("clear_locked", locked, 1);

        // Eight errors in a fresh window drop lock on the eighth.
        for (int i = 0; i < 8; i++) begin
            gen_bit(b);
            send(1'b1, ~b, 1'b0);
            if (i == 6) chk("locked_after_7err", locked, 1);
        end
        chk("unlock_8th", locked, 0);
        chk("unlock_err", err, 1);
        chk("unlock_err_cnt", err_cnt, 8);

        clean(51);
        chk("relock_bit51", locked, 0);
        clean(1);
        chk("relock_bit52", locked, 1);
        chk("relock_err_cnt", err_cnt, 8);

        // Asynchronous reset mid-lock.
        clean(5);
        #2 rst = 1'b0;
        #1;
        chk("async_locked", locked, 0);
        chk("async_err_cnt", err_cnt, 0);
        chk("async_bit_cnt", bit_cnt, 0);
        chk("async_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        g   = 20'd1;
        clean(52);
        chk("rst_relock", locked, 1);
        clean(3);
        gen_bit(b);
        send(1'b1, ~b, 1'b1);
        chk("clr_err_pulse", err, 1);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_bit_cnt", bit_cnt, 0);
        chk("clr_locked", locked, 1);
        clean(1);
        chk("clr_after_err_cnt", err_cnt, 0);
        chk("clr_after_bit_cnt", bit_cnt, 1);

        // en toggling; junk on invalid cycles must be ignored.
        do_reset();
        err_hi = 0;
        for (int i = 0; i < 52; i++) begin
            gen_bit(b);
            send(1'b1, b, 1'b0);
            if (i == 50) chk("toggle_bit51", locked, 0);
            send(1'b0, ~b, 1'b0);
        end
        chk("toggle_locked", locked, 1);
        chk("toggle_no_err", err_hi, 0);
        chk("toggle_err_cnt", err_cnt, 0);

        // All-zero input never locks.
        do_reset();
        err_hi = 0;
        repeat (200) send(1'b1, 1'b0, 1'b0);
        chk("zeros_locked", locked, 0);
        chk("zeros_no_err", err_hi, 0);

        send(1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
